// File: rtl/bit_serializer_if.sv
// ---------------------------------------------------------------------------
// bit_serializer_if
// Bundles the parallel word handshake and the serial output stream of
// bit_serializer.
//   in_data    : parallel word (producer -> serializer)
//   in_valid   : in_data valid (producer -> serializer)
//   in_ready   : serializer can accept a word this cycle
//   out_bit    : serial bit stream
//   out_active : out_bit carries a data bit rather than idle fill
//   word_start : pulse with the first bit of each word
//   fifo_level : words buffered, excluding the one being shifted
// master = word producer / stream consumer, slave = the serializer.
// ---------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_active;
    logic             word_start;
    logic [LW-1:0]    fifo_level;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  out_active,
        input  word_start,
        input  fifo_level
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_bit,
        output out_active,
        output word_start,
        output fifo_level
    );
endinterface

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial front end for the serial pattern detector. Words are
// accepted through a valid/ready handshake into a DEPTH-entry FIFO and shifted
// out one bit per clock with no gaps between consecutive words. IDLE_BIT is
// driven whenever nothing is in flight.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : bit_serializer_if.slave (in_data/in_valid/in_ready handshake,
//           registered out_bit/out_active/word_start, fifo_level)
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    bit_serializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WIDTH);

    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // First bit of a freshly loaded word, in the configured shift direction.
    function automatic logic first_bit(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? word[WIDTH-1] : word[0];
    endfunction

    // Word advanced by one position so the next bit sits at the output end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
    endfunction

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic [0:0]       state_r;
    logic             out_bit_r;
    logic             out_active_r;
    logic             word_start_r;

    logic             in_ready_s;
    logic             push_s;
    logic             load_slot_s;
    logic             pop_s;
    logic [WIDTH-1:0] head_s;

    // Readiness depends only on the registered level, so a full FIFO refuses
    // a push even when a pop happens on the same edge.
    assign in_ready_s  = (level_r < DEPTH_L) && !reset;
    assign push_s      = bus.in_valid && in_ready_s;
    // The shifter can take a new word when idle or right after its last bit
    // was driven (counter exhausted), which keeps the stream gap-free.
    assign load_slot_s = (state_r == ST_IDLE) || (cnt_r == {CW{1'b0}});
    assign pop_s       = (level_r != {LW{1'b0}}) && load_slot_s;
    assign head_s      = mem_r[rd_ptr_r];

    // FIFO storage and write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // FIFO read pointer and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Shifter FSM with registered serial outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            shift_r      <= {WIDTH{1'b0}};
            out_bit_r    <= IDLE_BIT;
            out_active_r <= 1'b0;
            word_start_r <= 1'b0;
        end else if (pop_s) begin
            state_r      <= ST_SHIFT;
            cnt_r        <= CNT_LOAD;
            shift_r      <= advance(head_s);
            out_bit_r    <= first_bit(head_s);
            out_active_r <= 1'b1;
            word_start_r <= 1'b1;
        end else if ((state_r == ST_SHIFT) && (cnt_r != {CW{1'b0}})) begin
            state_r      <= ST_SHIFT;
            cnt_r        <= cnt_r - CW'(1);
            shift_r      <= advance(shift_r);
            out_bit_r    <= first_bit(shift_r);
            out_active_r <= 1'b1;
            word_start_r <= 1'b0;
        end else begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            shift_r      <= shift_r;
            out_bit_r    <= IDLE_BIT;
            out_active_r <= 1'b0;
            word_start_r <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_bit    = out_bit_r;
    assign bus.out_active = out_active_r;
    assign bus.word_start = word_start_r;
    assign bus.fifo_level = level_r;
endmodule
